// File: rtl/gcd_requester.sv
// Initiator-side sequencer for the GCD FSMD core: accepts operand pairs, issues them
// to the core (or bypasses it for zero operands), and returns a bounded-latency result.
module gcd_requester #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 600,
  parameter int TO_W    = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             go_o,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  input  logic             core_done_i,
  input  logic [WIDTH-1:0] core_result_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] x_reg, x_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             err_reg, err_next;
  logic [TO_W-1:0]  timer_reg, timer_next;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      x_reg      <= '0;
      y_reg      <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
      timer_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      result_reg <= result_next;
      err_reg    <= err_next;
      timer_reg  <= timer_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    result_next = result_reg;
    err_next    = err_reg;
    timer_next  = timer_reg;
    case (state_reg)
      S_IDLE: begin
        if (in_valid) begin
          x_next = in_x;
          y_next = in_y;
          // Zero operands never reach the core: its subtract loop would not terminate.
          if (in_x == '0 && in_y == '0) begin
            result_next = '0;
            err_next    = 1'b1;
            state_next  = S_RESP;
          end else if (in_x == '0) begin
            result_next = in_y;
            err_next    = 1'b0;
            state_next  = S_RESP;
          end else if (in_y == '0) begin
            result_next = in_x;
            err_next    = 1'b0;
            state_next  = S_RESP;
          end else begin
            state_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        timer_next = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        timer_next = timer_reg + 1'b1;
        // A done arriving on the last allowed cycle still wins over the timeout.
        if (core_done_i) begin
          result_next = core_result_i;
          err_next    = 1'b0;
          state_next  = S_RESP;
        end else if (timer_reg == TIMER_LAST) begin
          result_next = '0;
          err_next    = 1'b1;
          state_next  = S_RESP;
        end
      end
      S_RESP: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign in_ready   = (state_reg == S_IDLE);
  assign go_o       = (state_reg == S_ISSUE);
  assign out_valid  = (state_reg == S_RESP);
  assign busy       = (state_reg != S_IDLE);
  assign x_o        = x_reg;
  assign y_o        = y_reg;
  assign out_result = result_reg;
  assign out_err    = err_reg;

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester: a vector table for single requests plus
// hand-written sequences for late done, backpressure and reset mid-WAIT.
module tb_gcd_requester;

  logic       CLK = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x, in_y;
  logic       go_o;
  logic [7:0] x_o, y_o;
  logic       core_done_i;
  logic [7:0] core_result_i;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  gcd_requester #(.WIDTH(8), .TIMEOUT(16), .TO_W(5)) dut (
    .CLK(CLK), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .go_o(go_o), .x_o(x_o), .y_o(y_o),
    .core_done_i(core_done_i), .core_result_i(core_result_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issues one request at a negedge in IDLE, plays the core (done 'dly' cycles
  // after go, never if dly<0), and returns at the first negedge with out_valid.
  task automatic do_req(input logic [7:0] x, input logic [7:0] y, input int dly,
                        input logic [7:0] res, output int go_cnt, output int lat,
                        output int busy_low);
    int  k;
    bit  go_seen;
    in_x = x; in_y = y; in_valid = 1'b1; core_result_i = res;
    @(negedge CLK);
    in_valid = 1'b0;
    go_cnt = 0; lat = 0; busy_low = 0; k = 0; go_seen = 0;
    for (int c = 1; c <= 100; c++) begin
      if (out_valid) begin
        lat = c;
        break;
      end
      if (!busy) busy_low++;
      if (go_o) begin
        go_cnt++;
        go_seen = 1;
      end else if (go_seen) begin
        k++;
      end
      core_done_i = go_seen && (k == dly);
      @(negedge CLK);
    end
    core_done_i = 1'b0;
    if (lat == 0) chk("out_valid_bound", 0, 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    int         dly;
    logic [7:0] res;
    logic [7:0] exp_r;
    logic       exp_e;
    int         exp_go;
    int         exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int go_cnt, lat, busy_low;

    vecs[0] = '{8'd48,  8'd18,  10, 8'd6,   8'd6,   1'b0, 1, 12};
    vecs[1] = '{8'd0,   8'd35,  -1, 8'd0,   8'd35,  1'b0, 0, 1};
    vecs[2] = '{8'd20,  8'd0,   -1, 8'd0,   8'd20,  1'b0, 0, 1};
    vecs[3] = '{8'd0,   8'd0,   -1, 8'd0,   8'd0,   1'b1, 0, 1};
    vecs[4] = '{8'd9,   8'd6,   -1, 8'd0,   8'd0,   1'b1, 1, 18};
    vecs[5] = '{8'd10,  8'd15,  16, 8'd5,   8'd5,   1'b0, 1, 18};
    vecs[6] = '{8'd255, 8'd255, 1,  8'd255, 8'd255, 1'b0, 1, 3};

    reset = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0;
    core_done_i = 1'b0; core_result_i = '0; out_ready = 1'b0;
    repeat (3) @(negedge CLK);
    reset = 1'b0;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_go", go_o, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", out_result, 0);
    chk("rst_err", out_err, 0);
    chk("rst_x_o", x_o, 0);

    for (int i = 0; i < 7; i++) begin
      do_req(vecs[i].x, vecs[i].y, vecs[i].dly, vecs[i].res, go_cnt, lat, busy_low);
      chk($sformatf("v%0d_result", i), out_result, vecs[i].exp_r);
      chk($sformatf("v%0d_err", i), out_err, vecs[i].exp_e);
      chk($sformatf("v%0d_go_pulses", i), go_cnt, vecs[i].exp_go);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_busy_low", i), busy_low, 0);
      chk($sformatf("v%0d_x_o", i), x_o, vecs[i].x);
      chk($sformatf("v%0d_y_o", i), y_o, vecs[i].y);
      handshake();
      chk($sformatf("v%0d_ready_after", i), in_ready, 1);
      $display("vec %0d: x=%0d y=%0d -> result=%0d err=%0d lat=%0d",
               i, vecs[i].x, vecs[i].y, out_result, out_err, lat);
    end

    // Timeout followed by a late done while the error response is pending.
    do_req(8'd9, 8'd6, -1, 8'd0, go_cnt, lat, busy_low);
    repeat (2) @(negedge CLK);
    core_done_i = 1'b1; core_result_i = 8'd99;
    @(negedge CLK);
    core_done_i = 1'b0;
    chk("late_done_result", out_result, 0);
    chk("late_done_err", out_err, 1);
    chk("late_done_valid", out_valid, 1);
    handshake();
    chk("late_done_in_ready", in_ready, 1);
    chk("late_done_valid_after", out_valid, 0);
    $display("late done: ignored, in_ready=%0d", in_ready);

    // Backpressure with a pending request behind it.
    do_req(8'd12, 8'd9, 4, 8'd3, go_cnt, lat, busy_low);
    in_x = 8'd7; in_y = 8'd7; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_result", out_result, 3);
      chk("bp_err", out_err, 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_x_o", x_o, 12);
      @(negedge CLK);
    end
    handshake();
    chk("bp_idle_in_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    chk("bp_idle_go", go_o, 0);
    @(negedge CLK);
    in_valid = 1'b0;
    chk("bp_next_go", go_o, 1);
    chk("bp_next_x_o", x_o, 7);
    core_result_i = 8'd7;
    @(negedge CLK);
    core_done_i = 1'b1;
    @(negedge CLK);
    core_done_i = 1'b0;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_result", out_result, 7);
    handshake();
    $display("backpressure: second result=7 delivered");

    // Reset four cycles into WAIT.
    in_x = 8'd15; in_y = 8'd10; in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    chk("rw_go", go_o, 1);
    repeat (4) @(negedge CLK);
    chk("rw_busy_before", busy, 1);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    chk("rw_in_ready", in_ready, 1);
    chk("rw_out_valid", out_valid, 0);
    chk("rw_go_after", go_o, 0);
    chk("rw_result", out_result, 0);
    chk("rw_x_o", x_o, 0);
    core_done_i = 1'b1; core_result_i = 8'd5;
    @(negedge CLK);
    core_done_i = 1'b0;
    chk("rw_done_dropped", out_valid, 0);
    chk("rw_busy_after", busy, 0);
    $display("reset mid-wait: in_ready=%0d out_valid=%0d", in_ready, out_valid);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
